// File: rtl/present_pkg.sv
// Shared constants, S-box tables and FSM encoding for the PRESENT sBoxLayer.
// PRESENT_SLAYER_INV_EN adds the inverse S-box table for decryption.
package present_pkg;

   localparam int STATE_W = 64;
   localparam int NIB_W   = 4;
   localparam int NIBBLES = 16;

   // Packed so that TABLE[x] returns S[x]; listed from index 15 down to 0.
   localparam logic [NIBBLES-1:0][NIB_W-1:0] SBOX_FWD = {
      4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
      4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
   };

`ifdef PRESENT_SLAYER_INV_EN
   localparam logic [NIBBLES-1:0][NIB_W-1:0] SBOX_INV = {
      4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
      4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5
   };
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_t;

endpackage

// File: rtl/present_sbox4.sv
// Combinational 4-bit PRESENT S-box lookup.
// With PRESENT_SLAYER_INV_EN an inv input selects the inverse table.
module present_sbox4
   import present_pkg::*;
(
   input  logic [NIB_W-1:0] x,
`ifdef PRESENT_SLAYER_INV_EN
   input  logic             inv,
`endif
   output logic [NIB_W-1:0] y
);

`ifdef PRESENT_SLAYER_INV_EN
   assign y = inv ? SBOX_INV[x] : SBOX_FWD[x];
`else
   assign y = SBOX_FWD[x];
`endif

endmodule

// File: rtl/present_slayer_serial.sv
// PRESENT sBoxLayer, LANES nibbles per cycle, valid/ready on both sides.
// PRESENT_SLAYER_INV_EN adds a decrypt input selecting the inverse S-box.
module present_slayer_serial
   import present_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
`ifdef PRESENT_SLAYER_INV_EN
   input  logic               decrypt,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state
);

   localparam int         N    = NIBBLES / LANES;
   localparam logic [3:0] LAST = 4'(N - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("present_slayer_serial: LANES must be 1, 2, 4, 8 or 16");
   end

   fsm_t                           fsm;
   logic [3:0]                     cnt;
   logic [STATE_W-1:0]             st_q;
   logic [STATE_W-1:0]             st_sub;
   logic                           rdy_q;
   logic                           out_valid_q;
   logic                           dec_q;
   logic                           dec_in;
   logic                           accept;
   logic [LANES-1:0][3:0]          nib_idx;
   logic [LANES-1:0][NIB_W-1:0]    sub_in;
   logic [LANES-1:0][NIB_W-1:0]    sub_out;

`ifdef PRESENT_SLAYER_INV_EN
   assign dec_in = decrypt;
`else
   assign dec_in = 1'b0;
`endif

   // In DONE the consumer's ready opens the input port in the same cycle,
   // letting the next state load on the edge that retires the result.
   assign in_ready  = rdy_q | (out_valid_q & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_state = st_q;

   always_comb begin
      nib_idx = '0;
      sub_in  = '0;
      for (int l = 0; l < LANES; l++) begin
         nib_idx[l] = 4'(int'(cnt) * LANES + l);
         sub_in[l]  = st_q[int'(nib_idx[l]) * NIB_W +: NIB_W];
      end
   end

   always_comb begin
      st_sub = st_q;
      for (int l = 0; l < LANES; l++)
         st_sub[int'(nib_idx[l]) * NIB_W +: NIB_W] = sub_out[l];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      present_sbox4 u_sbox (
         .x   (sub_in[l]),
`ifdef PRESENT_SLAYER_INV_EN
         .inv (dec_q),
`endif
         .y   (sub_out[l])
      );
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm         <= IDLE;
         cnt         <= '0;
         st_q        <= '0;
         rdy_q       <= 1'b0;
         out_valid_q <= 1'b0;
         dec_q       <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               rdy_q <= 1'b1;
               if (accept) begin
                  st_q  <= in_state;
                  cnt   <= '0;
                  dec_q <= dec_in;
                  rdy_q <= 1'b0;
                  fsm   <= BUSY;
               end
            end
            BUSY: begin
               st_q <= st_sub;
               // Counter parks on LAST rather than stepping past the end.
               if (cnt == LAST) begin
                  fsm         <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     st_q  <= in_state;
                     cnt   <= '0;
                     dec_q <= dec_in;
                     fsm   <= BUSY;
                  end else begin
                     rdy_q <= 1'b1;
                     fsm   <= IDLE;
                  end
               end
            end
            default: begin
               fsm         <= IDLE;
               rdy_q       <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifndef PRESENT_SLAYER_INV_EN
   logic unused_dec;
   assign unused_dec = dec_q;
`endif

endmodule
